// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: ALU select codes, default widths,
// ID/EX bundle and the forwarding-hit helper.
package mips_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   localparam logic [1:0] ALU_SEL_ADD = 2'b00;
   localparam logic [1:0] ALU_SEL_SUB = 2'b01;
   localparam logic [1:0] ALU_SEL_AND = 2'b10;
   localparam logic [1:0] ALU_SEL_OR  = 2'b11;

   typedef enum logic {
      RUN,
      BUBBLE
   } fsm_e;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_read;
      logic                  use_imm;
      logic [1:0]            alu_sel;
      logic [DEF_REG_W-1:0]  rs;
      logic [DEF_REG_W-1:0]  rt;
      logic [DEF_REG_W-1:0]  rd;
      logic [DEF_DATA_W-1:0] rs_data;
      logic [DEF_DATA_W-1:0] rt_data;
      logic [DEF_DATA_W-1:0] imm;
   } id_ex_t;

   // r0 is hardwired zero, so it never produces a hit
   function automatic logic fwd_hit(
      input logic                 we,
      input logic [DEF_REG_W-1:0] rd,
      input logic [DEF_REG_W-1:0] src
   );
      return we && (rd != '0) && (rd == src);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX handshake and operand bundle.
// master = decode side (drives id_*), slave = ID/EX stage (drives id_ready).
interface id_ex_stage_if
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W
);
   logic              id_valid;
   logic              id_ready;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;
   logic [1:0]        id_alu_sel;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic [REG_W-1:0]  id_rd;
   logic              id_reg_write;
   logic              id_mem_read;

   modport master (
      output id_valid, id_rs_data, id_rt_data, id_imm,
             id_use_imm, id_alu_sel, id_rs, id_rt, id_rd,
             id_reg_write, id_mem_read,
      input  id_ready
   );

   modport slave (
      input  id_valid, id_rs_data, id_rt_data, id_imm,
             id_use_imm, id_alu_sel, id_rs, id_rt, id_rd,
             id_reg_write, id_mem_read,
      output id_ready
   );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One-operand forwarding mux: src_i/data_i plus MEM and WB
// writeback sources in, selected operand on data_o (MEM wins).
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic [REG_W-1:0]  src_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              mem_we_i,
   input  logic [REG_W-1:0]  mem_rd_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              wb_we_i,
   input  logic [REG_W-1:0]  wb_rd_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] data_o
);
   always_comb begin
      data_o = data_i;
      priority case (1'b1)
         fwd_hit(mem_we_i, mem_rd_i, src_i): data_o = mem_data_i;
         fwd_hit(wb_we_i, wb_rd_i, src_i):   data_o = wb_data_i;
         default:                            data_o = data_i;
      endcase
   end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use / RAW stall and ALU operand forwarding.
// Ports: clk, rst_n, id (decode bundle, slave), flush, MEM/WB
// writeback sources, ALU operands/select and EX control out.
// Macro ID_EX_FORWARD_EN: forwarding on, only load-use stalls;
// undefined: no forwarding, stall on any EX/MEM RAW hazard.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   id_ex_stage_if.slave      id,
   input  logic              flush,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_reg_write,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic              wb_reg_write,
   input  logic [DATA_W-1:0] wb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_data1,
   output logic [DATA_W-1:0] alu_data2,
   output logic [1:0]        alu_sel,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read
);
   id_ex_t            ex_q, ex_d;
   fsm_e              state_q, state_d;
   logic              stall;
   logic [DATA_W-1:0] rs_fwd, rt_fwd;

`ifdef ID_EX_FORWARD_EN
   // A load-use bubble lasts exactly one cycle, so stalling is
   // only allowed from RUN.
   assign stall = id.id_valid && (state_q == RUN)
                  && ex_q.valid && ex_q.mem_read
                  && (ex_q.rd != '0)
                  && (id.id_rs == ex_q.rd || id.id_rt == ex_q.rd);
`else
   logic ex_hit, mem_hit;
   assign ex_hit = ex_q.valid
                   && (ex_q.reg_write || ex_q.mem_read)
                   && (ex_q.rd != '0)
                   && (id.id_rs == ex_q.rd || id.id_rt == ex_q.rd);
   assign mem_hit = fwd_hit(mem_reg_write, mem_rd, id.id_rs)
                    || fwd_hit(mem_reg_write, mem_rd, id.id_rt);
   assign stall = id.id_valid && (ex_hit || mem_hit);
`endif

   assign id.id_ready = !stall;

   always_comb begin
      ex_d           = ex_q;
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      priority case (1'b1)
         flush: ;
         stall: ;
         id.id_valid: begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = id.id_reg_write;
            ex_d.mem_read  = id.id_mem_read;
            ex_d.use_imm   = id.id_use_imm;
            ex_d.alu_sel   = id.id_alu_sel;
            ex_d.rs        = id.id_rs;
            ex_d.rt        = id.id_rt;
            ex_d.rd        = id.id_rd;
            ex_d.rs_data   = id.id_rs_data;
            ex_d.rt_data   = id.id_rt_data;
            ex_d.imm       = id.id_imm;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:    if (stall) state_d = BUBBLE;
`ifdef ID_EX_FORWARD_EN
         BUBBLE: state_d = RUN;
`else
         BUBBLE: if (!stall) state_d = RUN;
`endif
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q         <= '0;
         ex_q.alu_sel <= ALU_SEL_ADD;
         state_q      <= RUN;
      end else begin
         ex_q    <= ex_d;
         state_q <= state_d;
      end
   end

`ifdef ID_EX_FORWARD_EN
   fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
      .src_i      (ex_q.rs),
      .data_i     (ex_q.rs_data),
      .mem_we_i   (mem_reg_write),
      .mem_rd_i   (mem_rd),
      .mem_data_i (mem_result),
      .wb_we_i    (wb_reg_write),
      .wb_rd_i    (wb_rd),
      .wb_data_i  (wb_result),
      .data_o     (rs_fwd)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
      .src_i      (ex_q.rt),
      .data_i     (ex_q.rt_data),
      .mem_we_i   (mem_reg_write),
      .mem_rd_i   (mem_rd),
      .mem_data_i (mem_result),
      .wb_we_i    (wb_reg_write),
      .wb_rd_i    (wb_rd),
      .wb_data_i  (wb_result),
      .data_o     (rt_fwd)
   );
`else
   logic unused_fwd;
   assign rs_fwd     = ex_q.rs_data;
   assign rt_fwd     = ex_q.rt_data;
   assign unused_fwd = ^{mem_result, wb_rd, wb_reg_write,
                         wb_result, ex_q.rs, ex_q.rt};
`endif

   assign alu_data1    = rs_fwd;
   assign alu_data2    = ex_q.use_imm ? ex_q.imm : rt_fwd;
   assign alu_sel      = ex_q.alu_sel;
   assign ex_valid     = ex_q.valid;
   assign ex_rd        = ex_q.rd;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the MIPS datapath, sitting directly upstream of the ALU. It registers decoded operands and control from the decode stage, resolves data hazards by operand forwarding from the MEM and WB stages, and detects load-use hazards, stalling decode for one bubble. It drives the ALU's `data1`, `data2` and `sel` inputs.

## Interface
- `DATA_W`, 32, operand width
- `REG_W`, 5, register-number width
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `id_valid` in 1: decode presents an instruction
- `id_ready` out 1: stage accepts this cycle; equals `!stall`
- `id_rs_data`, `id_rt_data` in DATA_W: register-file read data
- `id_imm` in DATA_W: sign-extended immediate
- `id_use_imm` in 1: `data2` source is the immediate
- `id_alu_sel` in 2: ALU operation
- `id_rs`, `id_rt`, `id_rd` in REG_W: source and destination register numbers
- `id_reg_write`, `id_mem_read` in 1: writes register / is a load
- `flush` in 1: kill the instruction entering EX (branch redirect)
- `mem_rd` in REG_W, `mem_reg_write` in 1, `mem_result` in DATA_W: EX/MEM forwarding source
- `wb_rd` in REG_W, `wb_reg_write` in 1, `wb_result` in DATA_W: MEM/WB forwarding source
- `ex_valid` out 1: EX holds a real instruction
- `alu_data1`, `alu_data2` out DATA_W; `alu_sel` out 2: to the ALU
- `ex_rd` out REG_W; `ex_reg_write`, `ex_mem_read` out 1: forwarded to EX/MEM

## Operation
- Each cycle, one of three actions applies, in this priority:
  - `flush`: load a bubble.
  - `stall`: load a bubble; decode holds its instruction.
  - `id_valid`: capture all `id_*` fields.
  - Otherwise: load a bubble.
- A bubble sets `ex_valid=0`, `ex_reg_write=0` and `ex_mem_read=0`. The data fields of a bubble are don't-care.
- Load-use hazard: `stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (id_rs==ex_rd | id_rt==ex_rd)`.
- FSM with states RUN and BUBBLE.
  - RUN→BUBBLE when `stall` is asserted.
  - BUBBLE→RUN unconditionally after one cycle. A load-use stall never lasts more than one cycle.
- Forwarding is applied combinationally on the registered `rs`/`rt`. For each source:
  - MEM hit (`mem_reg_write & mem_rd!=0 & mem_rd==src`) selects `mem_result`.
  - Otherwise a WB hit selects `wb_result`.
  - Otherwise the captured register data is used.
  - MEM takes priority over WB; register 0 is never forwarded.
- `alu_data1` is the forwarded rs value.
- `alu_data2` is `use_imm ? imm : forwarded rt`.
- `alu_sel` is the registered `id_alu_sel`.

## Timing
- Reset values: `ex_valid=0`, `ex_reg_write=0`, `ex_mem_read=0`, `ex_rd=0`, `alu_sel=2'b00`, registered data fields 0. This gives `alu_data1=alu_data2=0` when no forwarding hit is present. FSM resets to RUN.
- Latency: decode fields appear at the ALU one cycle after the accepting edge.
- `id_ready` is combinational from the `id_*` inputs and EX state; it has no same-cycle dependency on `flush`.
- `flush` together with `stall`: the bubble is inserted and `id_ready` stays 0. Decode re-presents the instruction only if the branch unit has not killed it.
- Reset asserted mid-stall returns the FSM to RUN and clears `ex_valid` immediately (asynchronous).

## Configuration
- Macro `ID_EX_FORWARD_EN`.
- Defined: forwarding as described; only load-use hazards stall.
- Undefined:
  - Forwarding muxes are removed; `alu_data1`/`alu_data2` use the captured data.
  - The stall condition widens to any RAW hazard of `id_rs`/`id_rt` against a valid, writing EX or MEM destination (non-zero).
  - The stall persists while the condition holds; the FSM stays in BUBBLE until it clears.
  - The register file is write-before-read, so WB hazards do not stall.

## Structure
- Shared package `mips_pkg`:
  - ALU select encodings `ALU_SEL_*` (2'b00–2'b11).
  - `DATA_W` and `REG_W` defaults.
  - ID/EX bundle typedef.
- One sub-module: `fwd_mux` (one operand: source number, captured data, MEM/WB sources → selected data), instantiated twice.

## Test plan
- Reset mid-run: assert `rst_n=0` → all outputs at reset values, `id_ready=1` after release.
- Plain accept: `id_rs_data=5`, `id_rt_data=7`, `id_alu_sel=2'b01`, no hazards → next cycle `alu_data1=5`, `alu_data2=7`, `alu_sel=2'b01`, `ex_valid=1`.
- Forward priority: EX `rs=3`, `mem_rd=3`/`mem_result=0xAA`, `wb_rd=3`/`wb_result=0xBB` → `alu_data1=0xAA`; with `mem_rd=0` → `0xBB`; with `rs=0` → captured value.
- Load-use: EX holds a load to r4, ID reads r4 → `id_ready=0` for exactly one cycle, `ex_valid=0` next cycle, then the instruction enters with `wb_result` forwarded.
- Flush: `flush=1` with `id_valid=1` → `ex_valid=0`, `ex_reg_write=0` next cycle.
- Immediate: `id_use_imm=1`, `id_imm=0xFFFFFFFC` → `alu_data2=0xFFFFFFFC` regardless of any rt forwarding hit.
